mcu_arbiter: RTL and testbench

//   Shares the single MCU read port between three requesters:

---
 rtl/mcu_arbiter_if.sv | 29 ++
 rtl/mcu_arbiter.sv | 78 +++++++
 tb/tb_mcu_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mcu_arbiter_if.sv
// mcu_arbiter_if: requester handshake and MCU read-port signals of the MCU arbiter.
interface mcu_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              in_req0, in_req1, in_req2;
    logic [ADDR_W-1:0] in_addr0, in_addr1, in_addr2;
    logic [1:0]        in_size0, in_size1, in_size2;
    logic              out_ack0, out_ack1, out_ack2;
    logic [DATA_W-1:0] out_data;
    logic              out_mcu_ren;
    logic [ADDR_W-1:0] out_mcu_addr;
    logic [1:0]        out_mcu_size;
    logic [DATA_W-1:0] in_mcu_data;
    logic              out_busy;
    logic [1:0]        out_grant;
    modport slave (
        input  in_req0, in_req1, in_req2, in_addr0, in_addr1, in_addr2,
        input  in_size0, in_size1, in_size2, in_mcu_data,
        output out_ack0, out_ack1, out_ack2, out_data, out_mcu_ren,
        output out_mcu_addr, out_mcu_size, out_busy, out_grant
    );
    modport master (
        output in_req0, in_req1, in_req2, in_addr0, in_addr1, in_addr2,
        output in_size0, in_size1, in_size2, in_mcu_data,
        input  out_ack0, out_ack1, out_ack2, out_data, out_mcu_ren,
        input  out_mcu_addr, out_mcu_size, out_busy, out_grant
    );
endinterface

// File: rtl/mcu_arbiter.sv
// mcu_arbiter: shares one fixed-latency MCU read port between three requesters;
// req0 has strict priority, req1/req2 alternate on ties.
module mcu_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int MCU_LAT = 2
) (
    input logic         in_clk,
    input logic         in_rst_n,
    mcu_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MCU_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t            state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_last, grant, win, mcu_size, win_size;
    logic [2:0]        req, ack;
    logic              ren, busy;
    logic [ADDR_W-1:0] mcu_addr, win_addr;
    logic [DATA_W-1:0] data;
    assign req = {bus.in_req2, bus.in_req1, bus.in_req0};
    always_comb begin
        win      = req[0] ? 2'd0 : (req[1] && req[2]) ? ((r_last == 2'd1) ? 2'd2 : 2'd1) : req[1] ? 2'd1 : 2'd2;
        win_addr = (win == 2'd0) ? bus.in_addr0 : (win == 2'd1) ? bus.in_addr1 : bus.in_addr2;
        win_size = (win == 2'd0) ? bus.in_size0 : (win == 2'd1) ? bus.in_size1 : bus.in_size2;
    end
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state    <= IDLE;
            r_cnt    <= '0;
            r_last   <= 2'd2;
            grant    <= '0;
            ack      <= '0;
            ren      <= 1'b0;
            busy     <= 1'b0;
            mcu_addr <= '0;
            mcu_size <= '0;
            data     <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state    <= ISSUE;
                    busy     <= 1'b1;
                    ren      <= 1'b1;
                    mcu_addr <= win_addr;
                    mcu_size <= win_size;
                    grant    <= win;
                    r_cnt    <= CNT_W'(MCU_LAT - 1);
                    if (win != 2'd0) r_last <= win;
                end
                ISSUE: if (r_cnt == '0) begin
                    // MCU word is valid on the edge that ends the last ren cycle
                    state    <= DONE;
                    ren      <= 1'b0;
                    mcu_addr <= '0;
                    mcu_size <= '0;
                    data     <= bus.in_mcu_data;
                    ack      <= 3'b001 << grant;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign {bus.out_ack2, bus.out_ack1, bus.out_ack0} = ack;
    assign bus.out_data     = data;
    assign bus.out_mcu_ren  = ren;
    assign bus.out_mcu_addr = mcu_addr;
    assign bus.out_mcu_size = mcu_size;
    assign bus.out_busy     = busy;
    assign bus.out_grant    = grant;
endmodule

// File: tb/tb_mcu_arbiter.sv
// tb_mcu_arbiter: directed and random stimulus for mcu_arbiter, checked every cycle
// against a time-based transaction model plus hand-computed expectations.
module tb_mcu_arbiter;
    localparam int AW = 14, DW = 32, LAT = 2, LOGN = 4096;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mcu_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mcu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MCU_LAT(LAT)) dut (.in_clk(clk), .in_rst_n(rst_n), .bus(bus));
    logic [2:0]    req = '0, hold = '0;
    logic [AW-1:0] addr [3];
    logic [1:0]    size [3];
    assign bus.in_req0 = req[0];
    assign bus.in_req1 = req[1];
    assign bus.in_req2 = req[2];
    assign bus.in_addr0 = addr[0];
    assign bus.in_addr1 = addr[1];
    assign bus.in_addr2 = addr[2];
    assign bus.in_size0 = size[0];
    assign bus.in_size1 = size[1];
    assign bus.in_size2 = size[2];
    int cyc = 0;
    int ren_age = 0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ren_age <= bus.out_mcu_ren ? ren_age + 1 : 0;
    end
    // MCU returns the word only in the LAT-th consecutive cycle of ren
    assign bus.in_mcu_data = (bus.out_mcu_ren && ren_age == LAT - 1) ? DW'(bus.out_mcu_addr) : 32'hDEAD_BEEF;
    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask
    // Model: a service granted in IDLE cycle t0 occupies t0+1..t0+LAT+1
    bit m_valid = 0, m_act = 0;
    int m_t0 = 0, m_g = 0;
    logic [AW-1:0] m_la = '0;
    logic [1:0] m_ls = '0, m_last = 2'd2, m_grant = '0;
    logic [DW-1:0] m_data = '0;
    logic [2:0] e_ack = '0;
    logic [DW-1:0] e_data = '0;
    logic e_ren = 0, e_busy = 0;
    logic [AW-1:0] e_maddr = '0;
    logic [1:0] e_msize = '0, e_grant = '0;
    initial forever begin
        int el, w;
        @(negedge clk);
        if (!rst_n) begin
            m_valid = 1; m_act = 0; m_last = 2'd2; m_data = '0; m_grant = '0;
        end else if (m_valid && req != 0 && (!m_act || cyc - m_t0 >= LAT + 2)) begin
            w = req[0] ? 0 : (req[1] && req[2]) ? (m_last == 2'd1 ? 2 : 1) : req[1] ? 1 : 2;
            m_act = 1; m_t0 = cyc; m_g = w; m_la = addr[w]; m_ls = size[w]; m_grant = 2'(w);
            if (w != 0) m_last = 2'(w);
        end
        el = cyc + 1 - m_t0;
        e_ren  = m_act && el >= 1 && el <= LAT;
        e_busy = m_act && el >= 1 && el <= LAT + 1;
        e_ack  = (m_act && el == LAT + 1) ? 3'(1 << m_g) : 3'b000;
        if (e_ack != 0) m_data = DW'(m_la);
        e_maddr = e_ren ? m_la : '0;
        e_msize = e_ren ? m_ls : 2'b00;
        e_grant = m_grant;
        e_data  = m_data;
    end
    logic [2:0] ack_cur = '0, ack_prev = '0;
    logic [2:0] ack_log [LOGN];
    logic [DW-1:0] data_log [LOGN];
    logic [AW-1:0] maddr_log [LOGN];
    logic [1:0] grant_log [LOGN];
    logic ren_log [LOGN], busy_log [LOGN];
    initial forever begin
        @(posedge clk);
        #1;
        ack_prev = ack_cur;
        ack_cur = {bus.out_ack2, bus.out_ack1, bus.out_ack0};
        if (cyc < LOGN) begin
            ack_log[cyc] = ack_cur; data_log[cyc] = bus.out_data; maddr_log[cyc] = bus.out_mcu_addr;
            grant_log[cyc] = bus.out_grant; ren_log[cyc] = bus.out_mcu_ren; busy_log[cyc] = bus.out_busy;
        end
        if (m_valid) begin
            chk("ack", 32'(ack_cur), 32'(e_ack));
            chk("data", bus.out_data, e_data);
            chk("ren", 32'(bus.out_mcu_ren), 32'(e_ren));
            chk("mcu_addr", 32'(bus.out_mcu_addr), 32'(e_maddr));
            chk("mcu_size", 32'(bus.out_mcu_size), 32'(e_msize));
            chk("busy", 32'(bus.out_busy), 32'(e_busy));
            chk("grant", 32'(bus.out_grant), 32'(e_grant));
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) if (ack_prev[i] && !hold[i]) req[i] = 1'b0;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    initial begin
        int b, n_ack;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; size[i] = 2'b10; end
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        // single req1
        b = cyc; addr[1] = 14'h0123; req[1] = 1'b1;
        ticks(6);
        chk("t2_ren_c1", 32'(ren_log[b+1]), 1);
        chk("t2_ren_c2", 32'(ren_log[b+2]), 1);
        chk("t2_ren_c3", 32'(ren_log[b+3]), 0);
        chk("t2_addr", 32'(maddr_log[b+1]), 32'h0123);
        chk("t2_ack", 32'(ack_log[b+3]), 32'b010);
        chk("t2_data", data_log[b+3], 32'h0000_0123);
        chk("t2_idle", 32'(busy_log[b+4]), 0);
        // reset with all reqs high, then req1/req2 tie after release
        b = cyc; rst_n = 1'b0; req = 3'b111; addr[1] = 14'h0AAA; addr[2] = 14'h0BBB;
        ticks(3);
        chk("t1_rst_ren", 32'(ren_log[b+3]), 0);
        chk("t1_rst_busy", 32'(busy_log[b+3]), 0);
        chk("t1_rst_ack", 32'(ack_log[b+3]), 0);
        chk("t1_rst_data", data_log[b+3], 0);
        chk("t1_rst_grant", 32'(grant_log[b+3]), 0);
        b = cyc; req[0] = 1'b0; rst_n = 1'b1;
        ticks(12);
        chk("t1_grant", 32'(grant_log[b+1]), 1);
        chk("t1_ren_c1", 32'(ren_log[b+1]), 1);
        chk("t1_ren_c2", 32'(ren_log[b+2]), 1);
        chk("t1_ack2", 32'(ack_log[b+7]), 32'b100);
        // three-way contention
        b = cyc; addr[0] = 14'h0010; addr[1] = 14'h0020; addr[2] = 14'h0030; req = 3'b111;
        ticks(14);
        chk("t3_ack0", 32'(ack_log[b+3]), 32'b001);
        chk("t3_ack1", 32'(ack_log[b+7]), 32'b010);
        chk("t3_ack2", 32'(ack_log[b+11]), 32'b100);
        chk("t3_data2", data_log[b+11], 32'h30);
        n_ack = 0;
        for (int c = b; c <= b + 13; c++) n_ack += $countones(ack_log[c]);
        chk("t3_nack", 32'(n_ack), 3);
        // req1/req2 held high, re-requesting
        b = cyc; hold = 3'b110; addr[1] = 14'h0111; addr[2] = 14'h0222; req[1] = 1'b1; req[2] = 1'b1;
        ticks(16);
        chk("t4_s1", 32'(ack_log[b+3]), 32'b010);
        chk("t4_s2", 32'(ack_log[b+7]), 32'b100);
        chk("t4_s3", 32'(ack_log[b+11]), 32'b010);
        chk("t4_s4", 32'(ack_log[b+15]), 32'b100);
        hold = '0;
        ticks(12);
        // reset during ISSUE of req2
        b = cyc; addr[2] = 14'h0777; req[2] = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(6);
        chk("t5_ren_before", 32'(ren_log[b+1]), 1);
        chk("t5_ren_after", 32'(ren_log[b+2]), 0);
        n_ack = 0;
        for (int c = b + 1; c <= b + 4; c++) n_ack += $countones(ack_log[c]);
        chk("t5_no_ack", 32'(n_ack), 0);
        chk("t5_reserve", 32'(ack_log[b+5]), 32'b100);
        chk("t5_data", data_log[b+5], 32'h0777);
        // address change while granted
        b = cyc; addr[1] = 14'h0456; req[1] = 1'b1;
        tick();
        addr[1] = 14'h3FFF;
        ticks(5);
        chk("t6_addr_c1", 32'(maddr_log[b+1]), 32'h0456);
        chk("t6_addr_c2", 32'(maddr_log[b+2]), 32'h0456);
        chk("t6_ack", 32'(ack_log[b+3]), 32'b010);
        chk("t6_data", data_log[b+3], 32'h0456);
        req = '0;
        ticks(4);
        // random traffic with occasional resets
        for (int k = 0; k < 2500; k++) begin
            tick();
            rst_n = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1; addr[i] = 14'($urandom); size[i] = 2'($urandom);
                end else if (req[i] && $urandom_range(0, 7) == 0) begin
                    addr[i] = 14'($urandom); size[i] = 2'($urandom);
                end
                hold[i] = ($urandom_range(0, 5) == 0);
            end
        end
        rst_n = 1'b1; hold = '0;
        ticks(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
